// File: rtl/display_scheduler.sv
// rtl/display_scheduler.sv - six-digit display source scheduler (optional macro: LEADING_ZERO_BLANK_EN)
module display_scheduler #(
  parameter int TIME_SECS    = 8,
  parameter int DATE_SECS    = 3,
  parameter int EDIT_TIMEOUT = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en_1hz,
  input  logic        auto_en,
  input  logic [1:0]  sel,
  input  logic        edit_req,
  input  logic        alarm_on,
  input  logic [23:0] t_digits,
  input  logic [15:0] d_digits,
  input  logic [15:0] a_digits,
  output logic [23:0] dig_out,
  output logic [5:0]  blank,
  output logic [1:0]  src
);

  // S_ASET is the manual alarm-set view: it shows like EDIT but has no timeout
  // and follows sel, so it must not share the sticky EDIT state.
  typedef enum logic [2:0] {
    S_TIME  = 3'd0,
    S_DATE  = 3'd1,
    S_EDIT  = 3'd2,
    S_ALERT = 3'd3,
    S_ASET  = 3'd4
  } state_t;

  localparam logic [4:0] TIME_LAST = 5'(TIME_SECS - 1);
  localparam logic [4:0] DATE_LAST = 5'(DATE_SECS - 1);
  localparam logic [4:0] TMO_LAST  = 5'(EDIT_TIMEOUT - 1);

  state_t      r_state;
  logic [4:0]  r_dwell;
  logic [4:0]  r_tmo;
  logic        r_blink;
  logic        r_auto_prev;
  logic [23:0] r_dig;
  logic [5:0]  r_blank;
  logic [1:0]  r_src;

  state_t      w_state_nxt;
  logic [4:0]  w_dwell_nxt;
  logic [4:0]  w_tmo_nxt;
  logic        w_blink_nxt;
  logic [23:0] w_dig_nxt;
  logic [5:0]  w_blank_nxt;
  logic [1:0]  w_src_nxt;

  // Next-state and counter logic, priority ALERT > EDIT > auto/manual
  always_comb begin
    w_state_nxt = r_state;
    w_dwell_nxt = r_dwell;
    w_tmo_nxt   = r_tmo;
    w_blink_nxt = 1'b0;
    if (alarm_on) begin
      w_state_nxt = S_ALERT;
      w_dwell_nxt = 5'd0;
      w_tmo_nxt   = 5'd0;
      if (r_state == S_ALERT) begin
        w_blink_nxt = r_blink ^ en_1hz;
      end
    end else if (r_state == S_ALERT) begin
      w_state_nxt = S_TIME;
      w_dwell_nxt = 5'd0;
      w_tmo_nxt   = 5'd0;
    end else if (edit_req) begin
      w_state_nxt = S_EDIT;
      w_dwell_nxt = 5'd0;
      w_tmo_nxt   = 5'd0;
    end else if (r_state == S_EDIT) begin
      w_dwell_nxt = 5'd0;
      if (en_1hz) begin
        if (r_tmo == TMO_LAST) begin
          w_state_nxt = S_TIME;
          w_tmo_nxt   = 5'd0;
        end else begin
          w_tmo_nxt = r_tmo + 5'd1;
        end
      end
    end else if (auto_en) begin
      w_tmo_nxt = 5'd0;
      if (!r_auto_prev || (r_state == S_ASET)) begin
        // Entering auto mode always restarts the rotation on the time view.
        w_state_nxt = S_TIME;
        w_dwell_nxt = 5'd0;
      end else if (en_1hz) begin
        if (r_state == S_TIME) begin
          if (r_dwell == TIME_LAST) begin
            w_state_nxt = S_DATE;
            w_dwell_nxt = 5'd0;
          end else begin
            w_dwell_nxt = r_dwell + 5'd1;
          end
        end else begin
          if (r_dwell == DATE_LAST) begin
            w_state_nxt = S_TIME;
            w_dwell_nxt = 5'd0;
          end else begin
            w_dwell_nxt = r_dwell + 5'd1;
          end
        end
      end
    end else begin
      w_tmo_nxt   = 5'd0;
      w_dwell_nxt = 5'd0;
      case (sel)
        2'd1:    w_state_nxt = S_DATE;
        2'd2:    w_state_nxt = S_ASET;
        default: w_state_nxt = S_TIME;
      endcase
    end
  end

  // Output layout for the view being entered, so outputs lag inputs by one cycle
  always_comb begin
    w_dig_nxt   = t_digits;
    w_blank_nxt = 6'b000000;
    w_src_nxt   = 2'd0;
    case (w_state_nxt)
      S_DATE: begin
        w_dig_nxt   = {d_digits, 8'h00};
        w_blank_nxt = 6'b000011;
        w_src_nxt   = 2'd1;
`ifdef LEADING_ZERO_BLANK_EN
        w_blank_nxt[5] = (d_digits[15:12] == 4'd0);
`endif
      end
      S_EDIT, S_ASET: begin
        w_dig_nxt   = {a_digits, 8'h00};
        w_blank_nxt = 6'b000011;
        w_src_nxt   = 2'd2;
`ifdef LEADING_ZERO_BLANK_EN
        w_blank_nxt[5] = (a_digits[15:12] == 4'd0);
`endif
      end
      S_ALERT: begin
        w_src_nxt   = 2'd3;
        w_blank_nxt = w_blink_nxt ? 6'b111111 : 6'b000000;
`ifdef LEADING_ZERO_BLANK_EN
        if (!w_blink_nxt) begin
          w_blank_nxt[5] = (t_digits[23:20] == 4'd0);
        end
`endif
      end
      default: begin
`ifdef LEADING_ZERO_BLANK_EN
        w_blank_nxt[5] = (t_digits[23:20] == 4'd0);
`endif
      end
    endcase
  end

  // State, counters and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_TIME;
      r_dwell     <= 5'd0;
      r_tmo       <= 5'd0;
      r_blink     <= 1'b0;
      r_auto_prev <= 1'b0;
      r_dig       <= 24'd0;
      r_blank     <= 6'b000000;
      r_src       <= 2'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_dwell     <= w_dwell_nxt;
      r_tmo       <= w_tmo_nxt;
      r_blink     <= w_blink_nxt;
      r_auto_prev <= auto_en;
      r_dig       <= w_dig_nxt;
      r_blank     <= w_blank_nxt;
      r_src       <= w_src_nxt;
    end
  end

  assign dig_out = r_dig;
  assign blank   = r_blank;
  assign src     = r_src;

endmodule

// File: tb/tb_display_scheduler.sv
// tb/tb_display_scheduler.sv - directed bench for display_scheduler
module tb_display_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        en_1hz;
  logic        auto_en;
  logic [1:0]  sel;
  logic        edit_req;
  logic        alarm_on;
  logic [23:0] t_digits;
  logic [15:0] d_digits;
  logic [15:0] a_digits;
  logic [23:0] dig_out;
  logic [5:0]  blank;
  logic [1:0]  src;

  int errors = 0;
  int checks = 0;

  display_scheduler dut (
    .clk      (clk),
    .rst      (rst),
    .en_1hz   (en_1hz),
    .auto_en  (auto_en),
    .sel      (sel),
    .edit_req (edit_req),
    .alarm_on (alarm_on),
    .t_digits (t_digits),
    .d_digits (d_digits),
    .a_digits (a_digits),
    .dig_out  (dig_out),
    .blank    (blank),
    .src      (src)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      en_1hz = 1'b1;
      @(negedge clk);
      en_1hz = 1'b0;
    end
  endtask

  task automatic edit_pulse();
    edit_req = 1'b1;
    @(negedge clk);
    edit_req = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; alarm_on = 1'b1; edit_req = 1'b1; auto_en = 1'b1;
    step(2);
    checks++; if (dig_out !== 24'h0) begin errors++; $display("FAIL reset_dig got=%h exp=%h", dig_out, 24'h0); end
    checks++; if (blank !== 6'b0) begin errors++; $display("FAIL reset_blank got=%b exp=%b", blank, 6'b0); end
    checks++; if (src !== 2'd0) begin errors++; $display("FAIL reset_src got=%0d exp=0", src); end
    rst = 1'b0; alarm_on = 1'b0; edit_req = 1'b0;
    step(1);
    checks++; if (dig_out !== 24'h123456) begin errors++; $display("FAIL first_dig got=%h exp=123456", dig_out); end
    checks++; if (blank !== 6'b0) begin errors++; $display("FAIL first_blank got=%b exp=000000", blank); end
    checks++; if (src !== 2'd0) begin errors++; $display("FAIL first_src got=%0d exp=0", src); end
  endtask

  task automatic test_auto_rotation();
    tick(7);
    checks++; if (src !== 2'd0) begin errors++; $display("FAIL rot_7ticks_src got=%0d exp=0", src); end
    tick(1);
    checks++; if (src !== 2'd1) begin errors++; $display("FAIL rot_date_src got=%0d exp=1", src); end
    checks++; if (dig_out !== 24'h123100) begin errors++; $display("FAIL rot_date_dig got=%h exp=123100", dig_out); end
    checks++; if (blank !== 6'b000011) begin errors++; $display("FAIL rot_date_blank got=%b exp=000011", blank); end
    tick(2);
    checks++; if (src !== 2'd1) begin errors++; $display("FAIL rot_date_hold got=%0d exp=1", src); end
    tick(1);
    checks++; if (src !== 2'd0) begin errors++; $display("FAIL rot_back_time got=%0d exp=0", src); end
  endtask

  task automatic test_edit_timeout();
    tick(5);
    edit_pulse();
    checks++; if (src !== 2'd2) begin errors++; $display("FAIL edit_enter_src got=%0d exp=2", src); end
    checks++; if (dig_out !== 24'h163000) begin errors++; $display("FAIL edit_dig got=%h exp=163000", dig_out); end
    checks++; if (blank !== 6'b000011) begin errors++; $display("FAIL edit_blank got=%b exp=000011", blank); end
    tick(6);
    edit_pulse();
    tick(9);
    checks++; if (src !== 2'd2) begin errors++; $display("FAIL edit_hold9 got=%0d exp=2", src); end
    tick(1);
    checks++; if (src !== 2'd0) begin errors++; $display("FAIL edit_timeout_src got=%0d exp=0", src); end
    checks++; if (dig_out !== 24'h123456) begin errors++; $display("FAIL edit_exit_dig got=%h exp=123456", dig_out); end
    tick(7);
    checks++; if (src !== 2'd0) begin errors++; $display("FAIL edit_exit_dwell7 got=%0d exp=0", src); end
    tick(1);
    checks++; if (src !== 2'd1) begin errors++; $display("FAIL edit_exit_dwell8 got=%0d exp=1", src); end
  endtask

  task automatic test_alert();
    edit_pulse();
    checks++; if (src !== 2'd2) begin errors++; $display("FAIL alert_pre_edit got=%0d exp=2", src); end
    alarm_on = 1'b1;
    step(1);
    checks++; if (src !== 2'd3) begin errors++; $display("FAIL alert_src got=%0d exp=3", src); end
    checks++; if (blank !== 6'b0) begin errors++; $display("FAIL alert_blank0 got=%b exp=000000", blank); end
    checks++; if (dig_out !== 24'h123456) begin errors++; $display("FAIL alert_dig got=%h exp=123456", dig_out); end
    tick(1);
    checks++; if (blank !== 6'b111111) begin errors++; $display("FAIL alert_blink1 got=%b exp=111111", blank); end
    tick(1);
    checks++; if (blank !== 6'b0) begin errors++; $display("FAIL alert_blink2 got=%b exp=000000", blank); end
    edit_pulse();
    checks++; if (src !== 2'd3) begin errors++; $display("FAIL alert_edit_ignored got=%0d exp=3", src); end
    alarm_on = 1'b0;
    step(1);
    checks++; if (src !== 2'd0) begin errors++; $display("FAIL alert_exit_src got=%0d exp=0", src); end
    checks++; if (blank !== 6'b0) begin errors++; $display("FAIL alert_exit_blank got=%b exp=000000", blank); end
    tick(7);
    checks++; if (src !== 2'd0) begin errors++; $display("FAIL alert_exit_dwell7 got=%0d exp=0", src); end
    tick(1);
    checks++; if (src !== 2'd1) begin errors++; $display("FAIL alert_exit_dwell8 got=%0d exp=1", src); end
  endtask

  task automatic test_manual();
    auto_en = 1'b0; sel = 2'd0;
    step(1);
    checks++; if (src !== 2'd0) begin errors++; $display("FAIL man_sel0 got=%0d exp=0", src); end
    sel = 2'd1;
    checks++; if (src !== 2'd0) begin errors++; $display("FAIL man_lag got=%0d exp=0", src); end
    step(1);
    checks++; if (src !== 2'd1) begin errors++; $display("FAIL man_sel1 got=%0d exp=1", src); end
    checks++; if (dig_out !== 24'h123100) begin errors++; $display("FAIL man_sel1_dig got=%h exp=123100", dig_out); end
    sel = 2'd2;
    step(1);
    checks++; if (src !== 2'd2) begin errors++; $display("FAIL man_sel2 got=%0d exp=2", src); end
    checks++; if (dig_out !== 24'h163000) begin errors++; $display("FAIL man_sel2_dig got=%h exp=163000", dig_out); end
    sel = 2'd3;
    step(1);
    checks++; if (src !== 2'd0) begin errors++; $display("FAIL man_sel3 got=%0d exp=0", src); end
    sel = 2'd1;
    step(1);
    tick(12);
    checks++; if (src !== 2'd1) begin errors++; $display("FAIL man_no_rotate got=%0d exp=1", src); end
    auto_en = 1'b1;
    step(1);
    checks++; if (src !== 2'd0) begin errors++; $display("FAIL auto_restart got=%0d exp=0", src); end
    tick(7);
    checks++; if (src !== 2'd0) begin errors++; $display("FAIL auto_restart_dwell7 got=%0d exp=0", src); end
    tick(1);
    checks++; if (src !== 2'd1) begin errors++; $display("FAIL auto_restart_dwell8 got=%0d exp=1", src); end
  endtask

  task automatic test_edit_collision();
    edit_pulse();
    tick(9);
    checks++; if (src !== 2'd2) begin errors++; $display("FAIL coll_pre got=%0d exp=2", src); end
    edit_req = 1'b1; en_1hz = 1'b1;
    step(1);
    edit_req = 1'b0; en_1hz = 1'b0;
    checks++; if (src !== 2'd2) begin errors++; $display("FAIL coll_stay got=%0d exp=2", src); end
    tick(9);
    checks++; if (src !== 2'd2) begin errors++; $display("FAIL coll_restart9 got=%0d exp=2", src); end
    tick(1);
    checks++; if (src !== 2'd0) begin errors++; $display("FAIL coll_restart10 got=%0d exp=0", src); end
  endtask

  task automatic test_reset_in_alert();
    alarm_on = 1'b1;
    step(1);
    tick(1);
    checks++; if (blank !== 6'b111111) begin errors++; $display("FAIL rstal_blink got=%b exp=111111", blank); end
    rst = 1'b1;
    step(1);
    checks++; if (src !== 2'd0) begin errors++; $display("FAIL rstal_src got=%0d exp=0", src); end
    checks++; if (blank !== 6'b0) begin errors++; $display("FAIL rstal_blank got=%b exp=000000", blank); end
    checks++; if (dig_out !== 24'h0) begin errors++; $display("FAIL rstal_dig got=%h exp=000000", dig_out); end
    rst = 1'b0; alarm_on = 1'b0;
    step(1);
    checks++; if (src !== 2'd0) begin errors++; $display("FAIL rstal_after got=%0d exp=0", src); end
  endtask

  task automatic test_leading_zero();
    logic [5:0] exp_blank;
`ifdef LEADING_ZERO_BLANK_EN
    exp_blank = 6'b100000;
`else
    exp_blank = 6'b000000;
`endif
    t_digits = 24'h071500;
    step(1);
    checks++; if (dig_out !== 24'h071500) begin errors++; $display("FAIL lz_dig got=%h exp=071500", dig_out); end
    checks++; if (blank !== exp_blank) begin errors++; $display("FAIL lz_blank got=%b exp=%b", blank, exp_blank); end
  endtask

  initial begin
    rst = 1'b1; en_1hz = 1'b0; auto_en = 1'b1; sel = 2'd0; edit_req = 1'b0; alarm_on = 1'b0;
    t_digits = 24'h123456; d_digits = 16'h1231; a_digits = 16'h1630;
    @(negedge clk);
    test_reset();
    test_auto_rotation();
    test_edit_timeout();
    test_alert();
    test_manual();
    test_edit_collision();
    test_reset_in_alert();
    test_leading_zero();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
